// File: rtl/fpu_pcx_sched_if.sv
// Bundle of requester, PCX issue and CPX return signals for the FPU PCX scheduler.
interface fpu_pcx_sched_if #(
  parameter int unsigned NREQ = 8
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ*8-1:0]  req_op;
  logic [NREQ*2-1:0]  req_cc;
  logic [NREQ*2-1:0]  req_rnd;
  logic [NREQ-1:0]    req_fp2;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               pcx_fpio_data_rdy_px2;
  logic [123:0]       pcx_fpio_data_px2;
  logic [7:0]         fp_cpx_req_cq;
  logic [144:0]       fp_cpx_data_ca;
  logic [NREQ-1:0]    rsp_vld;
  logic [63:0]        rsp_data;
  logic [4:0]         rsp_flags;
  logic [2:0]         rsp_cc;
  logic [NREQ-1:0]    busy;
  logic [3:0]         credits;
  logic               err_unexp;

  modport slave (
    input  req_vld, req_op, req_cc, req_rnd, req_fp2, req_data, fp_cpx_req_cq, fp_cpx_data_ca,
    output req_ack, pcx_fpio_data_rdy_px2, pcx_fpio_data_px2, rsp_vld, rsp_data, rsp_flags,
           rsp_cc, busy, credits, err_unexp
  );

  modport master (
    output req_vld, req_op, req_cc, req_rnd, req_fp2, req_data, fp_cpx_req_cq, fp_cpx_data_ca,
    input  req_ack, pcx_fpio_data_rdy_px2, pcx_fpio_data_px2, rsp_vld, rsp_data, rsp_flags,
           rsp_cc, busy, credits, err_unexp
  );
endinterface

// File: rtl/fpu_pcx_sched.sv
// Round-robin sharing of one FPU PCX port among NREQ requesters, with credit-limited
// in-flight ops and CPX result routing back to the issuing requester.
module fpu_pcx_sched #(
  parameter int unsigned NREQ    = 8,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned GAP     = 1
) (
  input logic            gclk,
  input logic            arst_l,
  fpu_pcx_sched_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e          state_q, state_d;
  logic [2:0]      rr_q, rr_d, win_q, win_d, gap_q, gap_d;
  logic [123:0]    stage_q, stage_d, pkt_q, pkt_d;
  logic            rdy_q, rdy_d, err_q, err_d;
  logic [NREQ-1:0] ack_q, ack_d, busy_q, busy_d, rsp_vld_q, rsp_vld_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic [4:0]      rsp_flags_q, rsp_flags_d;
  logic [2:0]      rsp_cc_q, rsp_cc_d;
  logic [3:0]      credits_q, credits_d;
  logic [7:0]      cq_q, cq_d;

  logic [7:0]      elig, busy8, win_oh, ret_oh, fp2_8;
  logic [63:0]     op8;
  logic [15:0]     cc8, rnd8;
  logic [511:0]    data8;
  logic [2:0]      pick, ret_cpu;
  logic            found, ret_any, ret_ok, ret_inc, issue;
  int unsigned     idx;

  // Pad per-requester fields to 8 slots so every select index is exactly 3 bits wide.
  always_comb begin
    op8   = 64'(bus.req_op);
    cc8   = 16'(bus.req_cc);
    rnd8  = 16'(bus.req_rnd);
    data8 = 512'(bus.req_data);
    fp2_8 = 8'(bus.req_fp2);
    busy8 = 8'(busy_q);
    elig  = 8'(bus.req_vld & ~busy_q) & {8{credits_q != 4'd0}};
    found = 1'b0;
    pick  = 3'd0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(rr_q) + off) % NREQ;
      if (!found && elig[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // Returns: lowest set CPU bit of the registered req_cq owns the packet on data_ca.
  always_comb begin
    ret_cpu = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cq_q[i]) ret_cpu = 3'(i);
    end
    ret_any = |cq_q;
    ret_ok  = ret_any && bus.fp_cpx_data_ca[144] && (bus.fp_cpx_data_ca[143:140] == 4'b1000)
              && (32'(ret_cpu) < NREQ) && busy8[ret_cpu];
    ret_oh  = 8'd1 << ret_cpu;
    win_oh  = 8'd1 << win_q;
    issue   = (state_q == StIssue);
    ret_inc = ret_ok && !((credits_q == 4'(MAX_OUT)) && !issue);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    gap_d       = gap_q;
    stage_d     = stage_q;
    pkt_d       = pkt_q;
    rdy_d       = 1'b0;
    ack_d       = '0;
    busy_d      = busy_q;
    rsp_vld_d   = '0;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_cc_d    = rsp_cc_q;
    err_d       = err_q;
    cq_d        = bus.fp_cpx_req_cq;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          stage_d = {1'b1, (fp2_8[pick] ? 5'b01011 : 5'b01010), 1'b0, pick, 2'b00, 8'b0, 24'b0,
                     op8[{pick, 3'b000} +: 8], 4'b0, cc8[{pick, 1'b0} +: 2],
                     rnd8[{pick, 1'b0} +: 2], data8[{pick, 6'b0} +: 64]};
          state_d = StIssue;
        end
      end
      StIssue: begin
        rdy_d  = 1'b1;
        ack_d  = NREQ'(win_oh);
        pkt_d  = stage_q;
        busy_d = busy_d | NREQ'(win_oh);
        rr_d   = (32'(win_q) == NREQ - 1) ? 3'd0 : win_q + 3'd1;
        if (GAP == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StHold;
          gap_d   = 3'(GAP) - 3'd1;
        end
      end
      StHold: begin
        if (gap_q == 3'd0) state_d = StIdle;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase

    if (ret_ok) begin
      rsp_vld_d   = NREQ'(ret_oh);
      rsp_data_d  = bus.fp_cpx_data_ca[63:0];
      rsp_flags_d = bus.fp_cpx_data_ca[76:72];
      rsp_cc_d    = bus.fp_cpx_data_ca[69:67];
      busy_d      = busy_d & ~NREQ'(ret_oh);
    end
    if ((ret_any && !ret_ok) || (ret_ok && !ret_inc)) err_d = 1'b1;
    credits_d = credits_q + {3'b0, ret_inc} - {3'b0, issue};
  end

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q     <= StIdle;
      rr_q        <= 3'd0;
      win_q       <= 3'd0;
      gap_q       <= 3'd0;
      stage_q     <= '0;
      pkt_q       <= '0;
      rdy_q       <= 1'b0;
      ack_q       <= '0;
      busy_q      <= '0;
      rsp_vld_q   <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_cc_q    <= '0;
      credits_q   <= 4'(MAX_OUT);
      err_q       <= 1'b0;
      cq_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      gap_q       <= gap_d;
      stage_q     <= stage_d;
      pkt_q       <= pkt_d;
      rdy_q       <= rdy_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_cc_q    <= rsp_cc_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
      cq_q        <= cq_d;
    end
  end

  assign bus.req_ack               = ack_q;
  assign bus.pcx_fpio_data_rdy_px2 = rdy_q;
  assign bus.pcx_fpio_data_px2     = pkt_q;
  assign bus.rsp_vld               = rsp_vld_q;
  assign bus.rsp_data              = rsp_data_q;
  assign bus.rsp_flags             = rsp_flags_q;
  assign bus.rsp_cc                = rsp_cc_q;
  assign bus.busy                  = busy_q;
  assign bus.credits               = credits_q;
  assign bus.err_unexp             = err_q;
endmodule

// File: tb/tb_fpu_pcx_sched.sv
// Directed cycle table plus hand sequences for return errors and mid-issue reset.
module tb_fpu_pcx_sched;
  localparam logic [63:0] RDATA = 64'hC0FF_EE12_3456_789A;

  logic gclk = 1'b0;
  logic arst_l = 1'b0;
  always #5 gclk = ~gclk;

  fpu_pcx_sched_if #(.NREQ(8)) bus ();

  fpu_pcx_sched #(.NREQ(8), .MAX_OUT(4), .GAP(1)) dut (
    .gclk   (gclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] vld;
    logic [7:0] cq;
    logic       ca;
    logic [4:0] fl;
    logic       rdy;
    logic [7:0] ack;
    logic [7:0] busy;
    logic [3:0] cred;
    logic [7:0] rsp;
    logic       err;
    int         pw;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [123:0] exp_pkt(input int i);
    logic [7:0]  op;
    logic [1:0]  cc, rnd;
    logic [63:0] d;
    logic [2:0]  cpu;
    op  = 8'h41 + 8'(i);
    cc  = 2'(i);
    rnd = ~2'(i);
    d   = 64'h3FF0_0000_0000_0000 + 64'(i);
    cpu = 3'(i);
    return {1'b1, ((i % 2) == 1) ? 5'b01011 : 5'b01010, 1'b0, cpu, 2'b00, 8'b0, 24'b0, op, 4'b0,
            cc, rnd, d};
  endfunction

  function automatic logic [144:0] mk_ca(input logic [4:0] fl);
    logic [144:0] v;
    v = '0;
    v[144] = 1'b1;
    v[143:140] = 4'b1000;
    v[76:72] = fl;
    v[69:67] = 3'b101;
    v[63:0] = RDATA;
    return v;
  endfunction

  function automatic void add(input logic [7:0] vld, input logic [7:0] cq, input logic ca,
                              input logic [4:0] fl, input logic rdy, input logic [7:0] ack,
                              input logic [7:0] busy, input logic [3:0] cred,
                              input logic [7:0] rsp, input logic err, input int pw);
    vec_t v;
    v.vld = vld; v.cq = cq; v.ca = ca; v.fl = fl; v.rdy = rdy; v.ack = ack;
    v.busy = busy; v.cred = cred; v.rsp = rsp; v.err = err; v.pw = pw;
    tbl.push_back(v);
  endfunction

  task automatic chk_outs(input string p, input logic rdy, input logic [7:0] ack,
                          input logic [7:0] busy, input logic [3:0] cred, input logic [7:0] rsp,
                          input logic err);
    chk({p, ".rdy"}, 128'(bus.pcx_fpio_data_rdy_px2), 128'(rdy));
    chk({p, ".ack"}, 128'(bus.req_ack), 128'(ack));
    chk({p, ".busy"}, 128'(bus.busy), 128'(busy));
    chk({p, ".credits"}, 128'(bus.credits), 128'(cred));
    chk({p, ".rsp_vld"}, 128'(bus.rsp_vld), 128'(rsp));
    chk({p, ".err"}, 128'(bus.err_unexp), 128'(err));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      bus.req_op[8*i +: 8]    = 8'h41 + 8'(i);
      bus.req_cc[2*i +: 2]    = 2'(i);
      bus.req_rnd[2*i +: 2]   = ~2'(i);
      bus.req_fp2[i]          = (i % 2) == 1;
      bus.req_data[64*i +: 64] = 64'h3FF0_0000_0000_0000 + 64'(i);
    end
    bus.req_vld = '0;
    bus.fp_cpx_req_cq = '0;
    bus.fp_cpx_data_ca = '0;

    //  vld    cq     ca fl       rdy ack    busy   cred rsp   err pw
    add(8'h01, 8'h00, 0, 5'h00,   0, 8'h00, 8'h00, 4,  8'h00, 0, -1);
    add(8'h01, 8'h00, 0, 5'h00,   1, 8'h01, 8'h01, 3,  8'h00, 0,  0);
    add(8'hFE, 8'h00, 0, 5'h00,   0, 8'h00, 8'h01, 3,  8'h00, 0,  0);
    add(8'hFE, 8'h00, 0, 5'h00,   0, 8'h00, 8'h01, 3,  8'h00, 0,  0);
    add(8'hFE, 8'h00, 0, 5'h00,   1, 8'h02, 8'h03, 2,  8'h00, 0,  1);
    add(8'hFC, 8'h00, 0, 5'h00,   0, 8'h00, 8'h03, 2,  8'h00, 0,  1);
    add(8'hFC, 8'h00, 0, 5'h00,   0, 8'h00, 8'h03, 2,  8'h00, 0,  1);
    add(8'hFC, 8'h00, 0, 5'h00,   1, 8'h04, 8'h07, 1,  8'h00, 0,  2);
    add(8'hF8, 8'h00, 0, 5'h00,   0, 8'h00, 8'h07, 1,  8'h00, 0,  2);
    add(8'hF8, 8'h00, 0, 5'h00,   0, 8'h00, 8'h07, 1,  8'h00, 0,  2);
    add(8'hF8, 8'h00, 0, 5'h00,   1, 8'h08, 8'h0F, 0,  8'h00, 0,  3);
    add(8'hF0, 8'h00, 0, 5'h00,   0, 8'h00, 8'h0F, 0,  8'h00, 0,  3);
    add(8'hF0, 8'h00, 0, 5'h00,   0, 8'h00, 8'h0F, 0,  8'h00, 0,  3);
    add(8'hF0, 8'h00, 0, 5'h00,   0, 8'h00, 8'h0F, 0,  8'h00, 0,  3);
    add(8'hF0, 8'h04, 0, 5'h00,   0, 8'h00, 8'h0F, 0,  8'h00, 0,  3);
    add(8'hF0, 8'h00, 1, 5'h01,   0, 8'h00, 8'h0B, 1,  8'h04, 0,  3);
    add(8'hF0, 8'h00, 0, 5'h00,   0, 8'h00, 8'h0B, 1,  8'h00, 0,  3);
    add(8'hF0, 8'h00, 0, 5'h00,   1, 8'h10, 8'h1B, 0,  8'h00, 0,  4);
    add(8'hE0, 8'h20, 0, 5'h00,   0, 8'h00, 8'h1B, 0,  8'h00, 0,  4);
    add(8'hE0, 8'h00, 1, 5'h1F,   0, 8'h00, 8'h1B, 0,  8'h00, 1,  4);
    add(8'hE0, 8'h01, 0, 5'h00,   0, 8'h00, 8'h1B, 0,  8'h00, 1,  4);
    add(8'hE0, 8'h00, 1, 5'h10,   0, 8'h00, 8'h1A, 1,  8'h01, 1,  4);
    add(8'hE0, 8'h08, 0, 5'h00,   0, 8'h00, 8'h1A, 1,  8'h00, 1,  4);
    add(8'hE0, 8'h00, 1, 5'h04,   1, 8'h20, 8'h32, 1,  8'h08, 1,  5);
    add(8'hC0, 8'h00, 0, 5'h00,   0, 8'h00, 8'h32, 1,  8'h00, 1,  5);
    add(8'hC0, 8'h00, 0, 5'h00,   0, 8'h00, 8'h32, 1,  8'h00, 1,  5);
    add(8'hC0, 8'h00, 0, 5'h00,   1, 8'h40, 8'h72, 0,  8'h00, 1,  6);
    add(8'h80, 8'h00, 0, 5'h00,   0, 8'h00, 8'h72, 0,  8'h00, 1,  6);
    add(8'h80, 8'h00, 0, 5'h00,   0, 8'h00, 8'h72, 0,  8'h00, 1,  6);

    tick();
    tick();
    arst_l = 1'b1;
    tick();
    chk_outs("reset", 1'b0, 8'h00, 8'h00, 4'd4, 8'h00, 1'b0);
    chk("reset.pkt", 128'(bus.pcx_fpio_data_px2), 128'd0);

    for (int r = 0; r < tbl.size(); r++) begin
      bus.req_vld        = tbl[r].vld;
      bus.fp_cpx_req_cq  = tbl[r].cq;
      bus.fp_cpx_data_ca = tbl[r].ca ? mk_ca(tbl[r].fl) : '0;
      tick();
      chk_outs($sformatf("row%0d", r), tbl[r].rdy, tbl[r].ack, tbl[r].busy, tbl[r].cred,
               tbl[r].rsp, tbl[r].err);
      chk($sformatf("row%0d.pkt", r), 128'(bus.pcx_fpio_data_px2),
          (tbl[r].pw < 0) ? 128'd0 : 128'(exp_pkt(tbl[r].pw)));
      if (tbl[r].rsp != 8'h00) begin
        chk($sformatf("row%0d.rsp_data", r), 128'(bus.rsp_data), 128'(RDATA));
        chk($sformatf("row%0d.rsp_flags", r), 128'(bus.rsp_flags), 128'(tbl[r].fl));
        chk($sformatf("row%0d.rsp_cc", r), 128'(bus.rsp_cc), 128'(3'b101));
      end
    end

    // Free one slot (CPU 1), let requester 7 win, then reset while it is in ISSUE.
    bus.fp_cpx_req_cq = 8'h02;
    tick();
    bus.fp_cpx_req_cq = 8'h00;
    bus.fp_cpx_data_ca = mk_ca(5'h00);
    tick();
    bus.fp_cpx_data_ca = '0;
    chk_outs("ret1", 1'b0, 8'h00, 8'h70, 4'd1, 8'h02, 1'b1);
    tick();
    chk("pre_rst.rdy", 128'(bus.pcx_fpio_data_rdy_px2), 128'd0);
    arst_l = 1'b0;
    #1;
    chk_outs("in_rst", 1'b0, 8'h00, 8'h00, 4'd4, 8'h00, 1'b0);
    chk("in_rst.pkt", 128'(bus.pcx_fpio_data_px2), 128'd0);
    tick();
    tick();
    arst_l = 1'b1;
    bus.req_vld = 8'hFF;
    tick();
    tick();
    chk_outs("post_rst", 1'b1, 8'h01, 8'h01, 4'd3, 8'h00, 1'b0);
    chk("post_rst.pkt", 128'(bus.pcx_fpio_data_px2), 128'(exp_pkt(0)));
    bus.req_vld = 8'h00;

    // Late return for an op discarded by reset.
    bus.fp_cpx_req_cq = 8'h10;
    tick();
    bus.fp_cpx_req_cq = 8'h00;
    bus.fp_cpx_data_ca = mk_ca(5'h02);
    tick();
    bus.fp_cpx_data_ca = '0;
    chk_outs("stale", 1'b0, 8'h00, 8'h01, 4'd3, 8'h00, 1'b1);
    tick();
    chk("stale.sticky", 128'(bus.err_unexp), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
